// File: rtl/msrv32_pkg.sv
// Shared decode constants for the MSRV32 RV32I core: opcode classes,
// writeback-source, immediate-type and ALU operation codes.
package msrv32_pkg;

    // opcode[6:2] class codes; opcode[1:0] must be 2'b11 for any of these
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] WB_ALU     = 3'b000;
    localparam logic [2:0] WB_LU      = 3'b001;
    localparam logic [2:0] WB_IMM     = 3'b010;
    localparam logic [2:0] WB_IADDER  = 3'b011;
    localparam logic [2:0] WB_CSR     = 3'b100;
    localparam logic [2:0] WB_PC_PLUS = 3'b101;

    localparam logic [2:0] IMM_R   = 3'b000;
    localparam logic [2:0] IMM_I   = 3'b001;
    localparam logic [2:0] IMM_S   = 3'b010;
    localparam logic [2:0] IMM_B   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_J   = 3'b101;
    localparam logic [2:0] IMM_CSR = 3'b110;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/msrv32_decoder.sv
// MSRV32 instruction decoder: combinational decode captured in output registers.
// Optional MSRV32_DECODER_FUNCT3_CHECK_EN flags reserved funct3/funct7 encodings.
module msrv32_decoder
    import msrv32_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trap_taken_in,
    input  logic       funct7_5_in,
    input  logic [6:0] opcode_in,
    input  logic [2:0] funct3_in,
    input  logic [1:0] iadder_out_1_to_0_in,
    output logic [2:0] wb_mux_sel_out,
    output logic [2:0] imm_type_out,
    output logic [2:0] csr_op_out,
    output logic       mem_wr_reg_out,
    output logic [3:0] alu_opcode_out,
    output logic [1:0] load_size_out,
    output logic       load_unsigned_out,
    output logic       alu_src_out,
    output logic       iadder_src_out,
    output logic       csr_wr_en_out,
    output logic       rf_wr_en_out,
    output logic       illegal_instr_out,
    output logic       misaligned_load_out,
    output logic       misaligned_store_out
);

    logic       w_low_ok;
    logic       w_is_op, w_is_op_imm, w_is_load, w_is_store, w_is_branch;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_fence, w_is_system;
    logic       w_is_csr, w_class_hit, w_illegal, w_misaligned;
    logic [2:0] w_wb_mux_sel, w_imm_type;
    logic       w_alu_bit3;

    assign w_low_ok    = (opcode_in[1:0] == 2'b11);
    assign w_is_op     = w_low_ok && (opcode_in[6:2] == OPC_OP);
    assign w_is_op_imm = w_low_ok && (opcode_in[6:2] == OPC_OP_IMM);
    assign w_is_load   = w_low_ok && (opcode_in[6:2] == OPC_LOAD);
    assign w_is_store  = w_low_ok && (opcode_in[6:2] == OPC_STORE);
    assign w_is_branch = w_low_ok && (opcode_in[6:2] == OPC_BRANCH);
    assign w_is_jal    = w_low_ok && (opcode_in[6:2] == OPC_JAL);
    assign w_is_jalr   = w_low_ok && (opcode_in[6:2] == OPC_JALR);
    assign w_is_lui    = w_low_ok && (opcode_in[6:2] == OPC_LUI);
    assign w_is_auipc  = w_low_ok && (opcode_in[6:2] == OPC_AUIPC);
    assign w_is_fence  = w_low_ok && (opcode_in[6:2] == OPC_FENCE);
    assign w_is_system = w_low_ok && (opcode_in[6:2] == OPC_SYSTEM);

    // CSR forms are every SYSTEM funct3 except 000 (ECALL/EBREAK/xRET) and 100
    assign w_is_csr = w_is_system && (funct3_in[1:0] != 2'b00);

    assign w_class_hit = w_is_op | w_is_op_imm | w_is_load | w_is_store | w_is_branch |
                         w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_fence |
                         w_is_system;

    always_comb begin
        w_illegal = !w_class_hit || (w_is_system && (funct3_in == 3'b100));
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
        if (w_is_load && ((funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11)))
            w_illegal = 1'b1;
        if (w_is_store && (funct3_in >= 3'b011))
            w_illegal = 1'b1;
        if (w_is_branch && (funct3_in[2:1] == 2'b01))
            w_illegal = 1'b1;
        if (w_is_jalr && (funct3_in != 3'b000))
            w_illegal = 1'b1;
        if (w_is_op && funct7_5_in && (funct3_in != 3'b000) && (funct3_in != 3'b101))
            w_illegal = 1'b1;
        if (w_is_op_imm && funct7_5_in && (funct3_in == 3'b001))
            w_illegal = 1'b1;
`endif
    end

    always_comb begin
        case (funct3_in[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = iadder_out_1_to_0_in[0];
            default: w_misaligned = |iadder_out_1_to_0_in;
        endcase
    end

    always_comb begin
        w_wb_mux_sel = WB_ALU;
        if (w_is_load)                  w_wb_mux_sel = WB_LU;
        else if (w_is_lui)              w_wb_mux_sel = WB_IMM;
        else if (w_is_auipc)            w_wb_mux_sel = WB_IADDER;
        else if (w_is_csr)              w_wb_mux_sel = WB_CSR;
        else if (w_is_jal || w_is_jalr) w_wb_mux_sel = WB_PC_PLUS;
    end

    always_comb begin
        w_imm_type = IMM_R;
        if (w_is_op_imm || w_is_load || w_is_jalr) w_imm_type = IMM_I;
        else if (w_is_store)                       w_imm_type = IMM_S;
        else if (w_is_branch)                      w_imm_type = IMM_B;
        else if (w_is_lui || w_is_auipc)           w_imm_type = IMM_U;
        else if (w_is_jal)                         w_imm_type = IMM_J;
        else if (w_is_csr)                         w_imm_type = IMM_CSR;
    end

    // Only SRAI among immediates carries funct7[5] into the ALU op
    assign w_alu_bit3 = funct7_5_in && (w_is_op || (w_is_op_imm && (funct3_in == 3'b101)));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wb_mux_sel_out       <= '0;
            imm_type_out         <= '0;
            csr_op_out           <= '0;
            mem_wr_reg_out       <= 1'b0;
            alu_opcode_out       <= '0;
            load_size_out        <= '0;
            load_unsigned_out    <= 1'b0;
            alu_src_out          <= 1'b0;
            iadder_src_out       <= 1'b0;
            csr_wr_en_out        <= 1'b0;
            rf_wr_en_out         <= 1'b0;
            illegal_instr_out    <= 1'b0;
            misaligned_load_out  <= 1'b0;
            misaligned_store_out <= 1'b0;
        end else begin
            wb_mux_sel_out       <= w_wb_mux_sel;
            imm_type_out         <= w_imm_type;
            csr_op_out           <= funct3_in;
            mem_wr_reg_out       <= !w_illegal && w_is_store && !w_misaligned && !trap_taken_in;
            alu_opcode_out       <= {w_alu_bit3, funct3_in};
            load_size_out        <= funct3_in[1:0];
            load_unsigned_out    <= funct3_in[2];
            alu_src_out          <= w_is_op;
            iadder_src_out       <= w_is_load || w_is_store || w_is_jalr;
            csr_wr_en_out        <= !w_illegal && w_is_csr;
            rf_wr_en_out         <= !w_illegal && (w_is_op || w_is_op_imm || w_is_load ||
                                    w_is_lui || w_is_auipc || w_is_jal || w_is_jalr || w_is_csr);
            illegal_instr_out    <= w_illegal;
            misaligned_load_out  <= !w_illegal && w_is_load && w_misaligned;
            misaligned_store_out <= !w_illegal && w_is_store && w_misaligned;
        end
    end

endmodule

// File: tb/tb_msrv32_decoder.sv
// Self-checking bench for msrv32_decoder: directed cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_msrv32_decoder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       trap_taken_in;
    logic       funct7_5_in;
    logic [6:0] opcode_in;
    logic [2:0] funct3_in;
    logic [1:0] iadder_out_1_to_0_in;
    logic [2:0] wb_mux_sel_out, imm_type_out, csr_op_out;
    logic       mem_wr_reg_out;
    logic [3:0] alu_opcode_out;
    logic [1:0] load_size_out;
    logic       load_unsigned_out, alu_src_out, iadder_src_out, csr_wr_en_out;
    logic       rf_wr_en_out, illegal_instr_out, misaligned_load_out, misaligned_store_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_in = ~clk_in;

    msrv32_decoder dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .trap_taken_in        (trap_taken_in),
        .funct7_5_in          (funct7_5_in),
        .opcode_in            (opcode_in),
        .funct3_in            (funct3_in),
        .iadder_out_1_to_0_in (iadder_out_1_to_0_in),
        .wb_mux_sel_out       (wb_mux_sel_out),
        .imm_type_out         (imm_type_out),
        .csr_op_out           (csr_op_out),
        .mem_wr_reg_out       (mem_wr_reg_out),
        .alu_opcode_out       (alu_opcode_out),
        .load_size_out        (load_size_out),
        .load_unsigned_out    (load_unsigned_out),
        .alu_src_out          (alu_src_out),
        .iadder_src_out       (iadder_src_out),
        .csr_wr_en_out        (csr_wr_en_out),
        .rf_wr_en_out         (rf_wr_en_out),
        .illegal_instr_out    (illegal_instr_out),
        .misaligned_load_out  (misaligned_load_out),
        .misaligned_store_out (misaligned_store_out)
    );

    // Packed view: {wb,imm,csr_op,mem_wr,alu_op,ld_size,ld_uns,alu_src,ia_src,csr_we,rf_we,ill,mis_ld,mis_st}
    logic [23:0] dut_v;
    assign dut_v = {wb_mux_sel_out, imm_type_out, csr_op_out, mem_wr_reg_out, alu_opcode_out,
                    load_size_out, load_unsigned_out, alu_src_out, iadder_src_out,
                    csr_wr_en_out, rf_wr_en_out, illegal_instr_out,
                    misaligned_load_out, misaligned_store_out};

    // Reference model: decodes by whole instruction mnemonic class, alignment by modulo
    function automatic logic [23:0] model(input logic f7, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [1:0] ia,
                                          input logic trap);
        logic [2:0] wb, imm;
        logic alu3, alusrc, iasrc, rf, csr, st, ld, ill, mis, mw, ml, ms;
        int   size;
        wb = 3'd0; imm = 3'd0; alu3 = 0; alusrc = 0; iasrc = 0;
        rf = 0; csr = 0; st = 0; ld = 0; ill = 0;
        if (op[1:0] != 2'b11) ill = 1;
        else begin
            case (op)
                7'h33: begin rf = 1; alusrc = 1; alu3 = f7;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f7 && !(f3 == 0 || f3 == 5)) ill = 1;
`endif
                end
                7'h13: begin rf = 1; imm = 1; alu3 = (f3 == 5) ? f7 : 1'b0;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f7 && f3 == 1) ill = 1;
`endif
                end
                7'h03: begin rf = 1; wb = 1; imm = 1; iasrc = 1; ld = 1;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
`endif
                end
                7'h23: begin imm = 2; iasrc = 1; st = 1;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f3 >= 3) ill = 1;
`endif
                end
                7'h63: begin imm = 3;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f3 == 2 || f3 == 3) ill = 1;
`endif
                end
                7'h6F: begin rf = 1; wb = 5; imm = 5; end
                7'h67: begin rf = 1; wb = 5; imm = 1; iasrc = 1;
`ifdef MSRV32_DECODER_FUNCT3_CHECK_EN
                    if (f3 != 0) ill = 1;
`endif
                end
                7'h37: begin rf = 1; wb = 2; imm = 4; end
                7'h17: begin rf = 1; wb = 3; imm = 4; end
                7'h0F: ;
                7'h73: begin
                    if (f3 == 4) ill = 1;
                    else if (f3 != 0) begin csr = 1; rf = 1; wb = 4; imm = 6; end
                end
                default: ill = 1;
            endcase
        end
        size = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
        mis  = (int'(ia) % size) != 0;
        mw = st && !mis && !trap;
        ml = ld && mis;
        ms = st && mis;
        if (ill) begin rf = 0; csr = 0; mw = 0; ml = 0; ms = 0; end
        return {wb, imm, f3, mw, alu3, f3, f3[1:0], f3[2], alusrc, iasrc, csr, rf, ill, ml, ms};
    endfunction

    task automatic drive(input logic rst, input logic f7, input logic [6:0] op,
                         input logic [2:0] f3, input logic [1:0] ia, input logic trap);
        @(negedge clk_in);
        rst_in = rst; funct7_5_in = f7; opcode_in = op; funct3_in = f3;
        iadder_out_1_to_0_in = ia; trap_taken_in = trap;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        logic [23:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 7'b0110011, 3'b000, 2'b00, 1'b0);
            vectors++;
            if (dut_v !== 24'h0) begin
                errors++;
                $display("FAIL reset_edge%0d: got %h expected %h", i, dut_v, 24'h0);
            end
        end
        drive(1'b0, 1'b1, 7'b0110011, 3'b000, 2'b00, 1'b0);
        exp = model(1'b1, 7'b0110011, 3'b000, 2'b00, 1'b0);
        vectors++;
        if (dut_v !== exp) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", dut_v, exp);
        end
    endtask

    task automatic test_alu;
        logic [2:0] f3s [4] = '{3'b000, 3'b010, 3'b111, 3'b000};
        logic       f7s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] alu [4] = '{4'b0000, 4'b0010, 4'b0111, 4'b0000};
        drive(1'b0, 1'b1, 7'b0110011, 3'b000, 2'b00, 1'b0);
        vectors++;
        if ({alu_opcode_out, alu_src_out, rf_wr_en_out, wb_mux_sel_out, imm_type_out, illegal_instr_out}
            !== {4'b1000, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL op_sub: alu=%b src=%b rf=%b wb=%b imm=%b ill=%b expected alu=1000 src=1 rf=1 wb=000 imm=000 ill=0",
                     alu_opcode_out, alu_src_out, rf_wr_en_out, wb_mux_sel_out, imm_type_out, illegal_instr_out);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, f7s[i], 7'b0010011, f3s[i], 2'b00, 1'b0);
            vectors++;
            if ({alu_opcode_out, alu_src_out, imm_type_out} !== {alu[i], 1'b0, 3'b001}) begin
                errors++;
                $display("FAIL op_imm%0d: alu=%b src=%b imm=%b expected alu=%b src=0 imm=001",
                         i, alu_opcode_out, alu_src_out, imm_type_out, alu[i]);
            end
        end
    endtask

    task automatic test_system_illegal;
        drive(1'b0, 1'b0, 7'b1110011, 3'b111, 2'b00, 1'b0);
        vectors++;
        if ({wb_mux_sel_out, imm_type_out, csr_op_out, csr_wr_en_out, rf_wr_en_out, illegal_instr_out}
            !== {3'b100, 3'b110, 3'b111, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL csr_rrci: wb=%b imm=%b csr_op=%b cwe=%b rf=%b ill=%b expected 100 110 111 1 1 0",
                     wb_mux_sel_out, imm_type_out, csr_op_out, csr_wr_en_out, rf_wr_en_out, illegal_instr_out);
        end
        drive(1'b0, 1'b0, 7'b1110011, 3'b100, 2'b00, 1'b0);
        vectors++;
        if (illegal_instr_out !== 1'b1) begin
            errors++;
            $display("FAIL system_f3_100: ill=%b expected 1", illegal_instr_out);
        end
        drive(1'b0, 1'b0, 7'b1101100, 3'b010, 2'b00, 1'b0);
        vectors++;
        if ({illegal_instr_out, rf_wr_en_out, csr_wr_en_out, mem_wr_reg_out} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_opcode: ill=%b rf=%b cwe=%b mw=%b expected 1 0 0 0",
                     illegal_instr_out, rf_wr_en_out, csr_wr_en_out, mem_wr_reg_out);
        end
    endtask

    task automatic test_misaligned;
        drive(1'b0, 1'b0, 7'b0100011, 3'b010, 2'b10, 1'b0);
        vectors++;
        if ({misaligned_store_out, mem_wr_reg_out} !== 2'b10) begin
            errors++;
            $display("FAIL sw_misaligned: mis_st=%b mw=%b expected 1 0", misaligned_store_out, mem_wr_reg_out);
        end
        drive(1'b0, 1'b0, 7'b0100011, 3'b010, 2'b00, 1'b0);
        vectors++;
        if ({misaligned_store_out, mem_wr_reg_out} !== 2'b01) begin
            errors++;
            $display("FAIL sw_aligned: mis_st=%b mw=%b expected 0 1", misaligned_store_out, mem_wr_reg_out);
        end
        drive(1'b0, 1'b0, 7'b0100011, 3'b010, 2'b00, 1'b1);
        vectors++;
        if (mem_wr_reg_out !== 1'b0) begin
            errors++;
            $display("FAIL sw_trap: mw=%b expected 0", mem_wr_reg_out);
        end
        drive(1'b0, 1'b0, 7'b0000011, 3'b001, 2'b01, 1'b0);
        vectors++;
        if (misaligned_load_out !== 1'b1) begin
            errors++;
            $display("FAIL lh_misaligned: mis_ld=%b expected 1", misaligned_load_out);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] ia;
        logic f7, trap, rst;
        logic [23:0] exp;
        for (int i = 0; i < 600; i++) begin
            op   = ($urandom_range(3) != 0) ? ops[$urandom_range(10)] : 7'($urandom);
            f3   = 3'($urandom);
            ia   = 2'($urandom);
            f7   = 1'($urandom);
            trap = ($urandom_range(7) == 0);
            rst  = ($urandom_range(31) == 0);
            drive(rst, f7, op, f3, ia, trap);
            exp = rst ? 24'h0 : model(f7, op, f3, ia, trap);
            vectors++;
            if (dut_v !== exp) begin
                errors++;
                $display("FAIL random%0d op=%b f3=%b f7=%b ia=%b trap=%b rst=%b: got %h expected %h",
                         i, op, f3, f7, ia, trap, rst, dut_v, exp);
            end
        end
    endtask

    initial begin
        rst_in = 1'b1; trap_taken_in = 1'b0; funct7_5_in = 1'b0;
        opcode_in = '0; funct3_in = '0; iadder_out_1_to_0_in = '0;
        test_reset();
        test_alu();
        test_system_illegal();
        test_misaligned();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_decoder.md
Name: msrv32_decoder

Overview:
Instruction decoder for the MSRV32 RV32I core. It sits between the instruction fetch/immediate-adder stage and the execute/writeback datapath. It decodes opcode, funct3 and funct7[5] into datapath control signals, and flags illegal instructions and misaligned load/store addresses. All outputs are registered: one-cycle latency.

Parameters:
- none

Ports:
- clk_in  input  1  core clock; all outputs update on rising edge
- rst_in  input  1  synchronous, active-high reset
- trap_taken_in  input  1  trap being taken this cycle; suppresses memory write
- funct7_5_in  input  1  instruction bit 30 (funct7[5])
- opcode_in  input  7  instruction[6:0]
- funct3_in  input  3  instruction[14:12]
- iadder_out_1_to_0_in  input  2  low two bits of computed load/store address
- wb_mux_sel_out  output  3  writeback source: 000 ALU, 001 load unit, 010 immediate, 011 iadder, 100 CSR, 101 PC+4
- imm_type_out  output  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR
- csr_op_out  output  3  funct3 passthrough
- mem_wr_reg_out  output  1  store request
- alu_opcode_out  output  4  {alu bit3, funct3}
- load_size_out  output  2  funct3[1:0]
- load_unsigned_out  output  1  funct3[2]
- alu_src_out  output  1  1 = rs2, 0 = immediate
- iadder_src_out  output  1  1 = rs1 base, 0 = PC base
- csr_wr_en_out  output  1  CSR write enable
- rf_wr_en_out  output  1  register file write enable
- illegal_instr_out  output  1  illegal instruction
- misaligned_load_out  output  1  misaligned load address
- misaligned_store_out  output  1  misaligned store address

Behaviour:
- Combinational decode is captured in output registers on each clk_in rising edge. Latency is exactly 1 cycle.
- rst_in=1 at an edge: every output becomes 0. Reset has priority over decode.
- Opcode classes use opcode[6:2] and require opcode[1:0]=11:
  - OP 01100, OP_IMM 00100, LOAD 00000, STORE 01000, BRANCH 11000
  - JAL 11011, JALR 11001, LUI 01101, AUIPC 00101, FENCE 00011, SYSTEM 11100
- is_csr = SYSTEM and funct3 in {001,010,011,101,110,111}.
- illegal_instr = opcode[1:0]!=11, OR no class matches, OR (SYSTEM and funct3=100).
- An illegal instruction forces rf_wr_en, csr_wr_en, mem_wr_reg, misaligned_load and misaligned_store to 0.
- wb_mux_sel:
  - OP/OP_IMM → 000; LOAD → 001; LUI → 010; AUIPC → 011
  - is_csr → 100; JAL/JALR → 101; otherwise 000
- imm_type:
  - OP → 000; OP_IMM/LOAD/JALR → 001; STORE → 010; BRANCH → 011
  - LUI/AUIPC → 100; JAL → 101; is_csr → 110; otherwise 000
- alu_opcode[2:0] = funct3.
- alu_opcode[3] = funct7_5 when OP, or when OP_IMM with funct3=101 (SRLI/SRAI); else 0.
- Resulting ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- alu_src = 1 only for OP.
- iadder_src = 1 for LOAD, STORE, JALR; else 0.
- rf_wr_en = OP | OP_IMM | LOAD | LUI | AUIPC | JAL | JALR | is_csr.
- csr_wr_en = is_csr. csr_op = funct3. load_size = funct3[1:0]. load_unsigned = funct3[2]. These three follow funct3 regardless of class.
- Misalignment depends on funct3[1:0]:
  - word (10): iadder[1:0]!=00
  - half (01): iadder[0]=1
  - byte (00): never
  - 11: treated as word
- misaligned_load = LOAD & misaligned. misaligned_store = STORE & misaligned.
- mem_wr_reg = STORE & ~misaligned & ~trap_taken_in.

Optional Feature:
- Macro: MSRV32_DECODER_FUNCT3_CHECK_EN.
- Defined: illegal_instr is additionally asserted for:
  - LOAD funct3 in {011,110,111}
  - STORE funct3 ≥ 011
  - BRANCH funct3 in {010,011}
  - JALR funct3 != 000
  - OP with funct7_5=1 and funct3 not in {000,101}
  - OP_IMM funct3=001 with funct7_5=1
- Undefined: none of these extra checks; only the base rules apply.

Decomposition:
- Package msrv32_pkg: opcode class constants, WB_* codes, IMM_* codes, ALU_* codes.
- Sub-module: none needed. Combinational decode plus one output register block live in one module.

Test Plan:
- Reset held 1 for 2 edges with OP SUB applied → all outputs 0. First edge after release → decoded values appear.
- OP, funct7_5=1, funct3=000 → alu_opcode 1000, alu_src 1, rf_wr_en 1, wb 000, imm 000, illegal 0.
- OP_IMM, funct7_5=0: funct3 000/010/111 → alu_opcode 0000/0010/0111, alu_src 0, imm 001. Same with funct7_5=1, funct3=000 → still 0000.
- SYSTEM 1110011, funct3=111 → wb 100, imm 110, csr_op 111, csr_wr_en 1, rf_wr_en 1, illegal 0. funct3=100 → illegal 1.
- Opcode 1101100 → illegal 1, rf_wr_en 0, csr_wr_en 0, mem_wr 0.
- STORE 0100011, funct3=010:
  - iadder 10 → misaligned_store 1, mem_wr 0
  - iadder 00 → mem_wr 1
  - iadder 00 with trap_taken_in=1 → mem_wr 0
- LOAD funct3=001 (LH), iadder 01 → misaligned_load 1.
